// File: rtl/iob_cache_be_arb_pkg.sv
// Shared types for the cache back-end arbiter.
// State encoding and byte-lane helpers.
package iob_cache_be_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int NBYTES = DEF_DATA_W / 8;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_cache_rr_arb2.sv
// Two-way round-robin decision.
// The client that was served last loses a tie.
module iob_cache_rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  input  logic en,
  output logic grant,
  output logic win
);

  always_comb begin
    grant = 1'b0;
    unique case ({v1, v0})
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
    win = en & (v0 | v1);
  end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Shares one cache back-end memory port between two clients.
// Whole transactions are serialised; grant is held until done.
module iob_cache_be_arbiter
  import iob_cache_be_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                req0_valid_i,
  input  logic [ADDR_W-1:0]   req0_addr_i,
  input  logic [DATA_W-1:0]   req0_wdata_i,
  input  logic [DATA_W/8-1:0] req0_wstrb_i,
  input  logic [LEN_W-1:0]    req0_len_i,
  output logic                req0_ready_o,
  output logic                req0_rvalid_o,
  output logic [DATA_W-1:0]   req0_rdata_o,
  output logic                req0_rlast_o,
  input  logic                req1_valid_i,
  input  logic [ADDR_W-1:0]   req1_addr_i,
  input  logic [DATA_W-1:0]   req1_wdata_i,
  input  logic [DATA_W/8-1:0] req1_wstrb_i,
  input  logic [LEN_W-1:0]    req1_len_i,
  output logic                req1_ready_o,
  output logic                req1_rvalid_o,
  output logic [DATA_W-1:0]   req1_rdata_o,
  output logic                req1_rlast_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic [LEN_W-1:0]    m_len_o,
  input  logic                m_ready_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i
);

  localparam int NB = nbytes(DATA_W);

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              last_grant;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_q;
  logic              arb_grant;
  logic              arb_win;
  logic              last_beat;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NB-1:0]     sel_wstrb;
  logic [LEN_W-1:0]  sel_len;

  iob_cache_rr_arb2 u_rr (
    .v0         (req0_valid_i),
    .v1         (req1_valid_i),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .grant      (arb_grant),
    .win        (arb_win)
  );

  assign sel_addr  = grant ? req1_addr_i  : req0_addr_i;
  assign sel_wdata = grant ? req1_wdata_i : req0_wdata_i;
  assign sel_wstrb = grant ? req1_wstrb_i : req0_wstrb_i;
  assign sel_len   = grant ? req1_len_i   : req0_len_i;
  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_win) state_nxt = REQ;
      REQ:     if (m_ready_i)
                 state_nxt = (|sel_wstrb) ? IDLE : RDATA;
      RDATA:   if (m_rvalid_i && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid_o     = 1'b0;
    m_addr_o      = '0;
    m_wdata_o     = '0;
    m_wstrb_o     = '0;
    m_len_o       = '0;
    req0_ready_o  = 1'b0;
    req1_ready_o  = 1'b0;
    req0_rvalid_o = 1'b0;
    req1_rvalid_o = 1'b0;
    req0_rdata_o  = '0;
    req1_rdata_o  = '0;
    req0_rlast_o  = 1'b0;
    req1_rlast_o  = 1'b0;
    unique case (state)
      REQ: begin
        m_valid_o    = 1'b1;
        m_addr_o     = sel_addr;
        m_wdata_o    = sel_wdata;
        m_wstrb_o    = sel_wstrb;
        m_len_o      = sel_len;
        req0_ready_o = m_ready_i & ~grant;
        req1_ready_o = m_ready_i & grant;
      end
      RDATA: begin
        req0_rvalid_o = m_rvalid_i & ~grant;
        req1_rvalid_o = m_rvalid_i & grant;
        req0_rdata_o  = req0_rvalid_o ? m_rdata_i : '0;
        req1_rdata_o  = req1_rvalid_o ? m_rdata_i : '0;
        req0_rlast_o  = req0_rvalid_o & last_beat;
        req1_rlast_o  = req1_rvalid_o & last_beat;
      end
      default: ;
    endcase
  end

  // Grant is captured once per transaction and held to completion.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      len_q      <= '0;
    end else begin
      if (state == IDLE && arb_win) grant <= arb_grant;
      if (state == REQ && m_ready_i) begin
        last_grant <= grant;
        len_q      <= m_len_o;
        beat_cnt   <= '0;
      end
      if (state == RDATA && m_rvalid_i) beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Randomised bench for iob_cache_be_arbiter.
// Expected traffic comes from the bench's own transaction model.
module tb_iob_cache_be_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        req0_valid_i = 0, req1_valid_i = 0;
  logic [31:0] req0_addr_i = 0, req1_addr_i = 0;
  logic [31:0] req0_wdata_i = 0, req1_wdata_i = 0;
  logic [3:0]  req0_wstrb_i = 0, req1_wstrb_i = 0;
  logic [7:0]  req0_len_i = 0, req1_len_i = 0;
  logic        req0_ready_o, req1_ready_o;
  logic        req0_rvalid_o, req1_rvalid_o;
  logic [31:0] req0_rdata_o, req1_rdata_o;
  logic        req0_rlast_o, req1_rlast_o;
  logic        m_valid_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic [7:0]  m_len_o;
  logic        m_ready_i = 0, m_rvalid_i = 0;
  logic [31:0] m_rdata_i = 0;

  int checks = 0;
  int errors = 0;
  logic pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;

  always #5 clk_i = ~clk_i;

  iob_cache_be_arbiter dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i),
    .req0_wdata_i(req0_wdata_i), .req0_wstrb_i(req0_wstrb_i),
    .req0_len_i(req0_len_i), .req0_ready_o(req0_ready_o),
    .req0_rvalid_o(req0_rvalid_o), .req0_rdata_o(req0_rdata_o),
    .req0_rlast_o(req0_rlast_o),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i),
    .req1_wdata_i(req1_wdata_i), .req1_wstrb_i(req1_wstrb_i),
    .req1_len_i(req1_len_i), .req1_ready_o(req1_ready_o),
    .req1_rvalid_o(req1_rvalid_o), .req1_rdata_o(req1_rdata_o),
    .req1_rlast_o(req1_rlast_o),
    .m_valid_o(m_valid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_len_o(m_len_o), .m_ready_i(m_ready_i),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
  );

  // A client must not withdraw a request before it has been accepted.
  always @(posedge clk_i) begin
    if (arst_n_i) begin
      if (pv0 && !pr0 && !req0_valid_i) begin
        errors++;
        $display("FAIL proto0: valid dropped before ready");
      end
      if (pv1 && !pr1 && !req1_valid_i) begin
        errors++;
        $display("FAIL proto1: valid dropped before ready");
      end
    end
    pv0 <= req0_valid_i; pr0 <= req0_ready_o;
    pv1 <= req1_valid_i; pr1 <= req1_ready_o;
  end

  function automatic logic rdy(input int k);
    return (k == 1) ? req1_ready_o : req0_ready_o;
  endfunction
  function automatic logic rv(input int k);
    return (k == 1) ? req1_rvalid_o : req0_rvalid_o;
  endfunction
  function automatic logic rl(input int k);
    return (k == 1) ? req1_rlast_o : req0_rlast_o;
  endfunction
  function automatic logic [31:0] rdat(input int k);
    return (k == 1) ? req1_rdata_o : req0_rdata_o;
  endfunction

  task automatic set_req(input int k, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [7:0] l);
    if (k == 0) begin
      req0_valid_i = v; req0_addr_i = a; req0_wdata_i = d;
      req0_wstrb_i = s; req0_len_i = l;
    end else begin
      req1_valid_i = v; req1_addr_i = a; req1_wdata_i = d;
      req1_wstrb_i = s; req1_len_i = l;
    end
  endtask

  // One uncontended transaction from client k, starting from IDLE.
  task automatic run_txn(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [7:0] l,
                         input int rdy_dly, input int gap_max, input bit seq);
    logic [3:0]  s;
    logic [31:0] rd;
    int          gap;
    s = wr ? 4'($urandom_range(1, 15)) : 4'h0;
    @(negedge clk_i);
    set_req(k, 1'b1, a, d, s, l);
    m_ready_i = (rdy_dly == 0);
    m_rvalid_i = 1'b0;
    #1; checks++;
    if (m_valid_o !== 1'b0) begin
      errors++; $display("FAIL idle_mvalid: got %b want 0", m_valid_o);
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk_i);
      m_ready_i = (i == rdy_dly);
      #1; checks++;
      if ({m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o, m_len_o} !==
          {1'b1, a, d, s, l}) begin
        errors++;
        $display("FAIL req_fields: got %b %h %h %h %h want 1 %h %h %h %h",
                 m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o, m_len_o,
                 a, d, s, l);
      end
      checks++;
      if ({rdy(k), rdy(1 - k)} !== {(i == rdy_dly), 1'b0}) begin
        errors++;
        $display("FAIL req_ready: got %b%b want %b0", rdy(k), rdy(1 - k),
                 (i == rdy_dly));
      end
    end
    @(negedge clk_i);
    set_req(k, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b0;
    if (!wr) begin
      for (int b = 0; b <= int'(l); b++) begin
        gap = $urandom_range(0, gap_max);
        for (int g = 0; g < gap; g++) begin
          m_rvalid_i = 1'b0;
          #1; checks++;
          if ({req0_rvalid_o, req1_rvalid_o} !== 2'b00) begin
            errors++; $display("FAIL gap_rvalid: got %b%b want 00",
                               req0_rvalid_o, req1_rvalid_o);
          end
          @(negedge clk_i);
        end
        rd = seq ? 32'hA0 + b : $urandom;
        m_rvalid_i = 1'b1;
        m_rdata_i = rd;
        #1; checks++;
        if ({rv(k), rl(k), rdat(k)} !== {1'b1, (b == int'(l)), rd}) begin
          errors++;
          $display("FAIL beat%0d: got v%b l%b %h want v1 l%b %h", b,
                   rv(k), rl(k), rdat(k), (b == int'(l)), rd);
        end
        checks++;
        if ({rv(1 - k), rl(1 - k)} !== 2'b00) begin
          errors++; $display("FAIL other_beat: got %b%b want 00",
                             rv(1 - k), rl(1 - k));
        end
        @(negedge clk_i);
      end
    end
    m_rvalid_i = 1'b0;
    #1; checks++;
    if ({m_valid_o, req0_rvalid_o, req1_rvalid_o, req0_ready_o,
         req1_ready_o} !== 5'b0) begin
      errors++; $display("FAIL done_idle: got %b%b%b%b%b want 00000",
                         m_valid_o, req0_rvalid_o, req1_rvalid_o,
                         req0_ready_o, req1_ready_o);
    end
  endtask

  task automatic test_reset();
    arst_n_i = 1'b0;
    @(negedge clk_i);
    set_req(0, 1'b1, $urandom, $urandom, 4'hF, 8'd3);
    set_req(1, 1'b1, $urandom, $urandom, 4'h0, 8'd7);
    m_ready_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = $urandom;
    #1; checks++;
    if ({req0_ready_o, req0_rvalid_o, req0_rdata_o, req0_rlast_o,
         req1_ready_o, req1_rvalid_o, req1_rdata_o, req1_rlast_o,
         m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o, m_len_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero want all 0");
    end
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b0; m_rvalid_i = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(negedge clk_i);
    #1; checks++;
    if (m_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got %b want 0", m_valid_o);
    end
  endtask

  task automatic test_single_write();
    run_txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 8'd0, 0, 0, 1'b0);
  endtask

  task automatic test_read_burst();
    run_txn(1, 1'b0, 32'h200, 32'h0, 8'd3, 0, 3, 1'b1);
  endtask

  task automatic test_contention();
    logic [31:0] a [2];
    int served [2];
    bit upd [2];
    bit pend [2];
    int last_srv, n, k, exp_k;
    arst_n_i = 1'b0;
    for (int j = 0; j < 2; j++) begin
      a[j] = $urandom; served[j] = 0; upd[j] = 0; pend[j] = 1;
      set_req(j, 1'b1, a[j], $urandom, 4'hF, 8'd0);
    end
    m_ready_i = 1'b1;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    last_srv = 1; n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk_i);
      for (int j = 0; j < 2; j++) if (upd[j]) begin
        upd[j] = 0;
        if (served[j] < 2) begin
          a[j] = $urandom;
          set_req(j, 1'b1, a[j], $urandom, 4'hF, 8'd0);
        end else begin
          set_req(j, 1'b0, '0, '0, '0, '0);
          pend[j] = 0;
        end
      end
      #1;
      if (req0_ready_o || req1_ready_o) begin
        k = req1_ready_o ? 1 : 0;
        exp_k = (pend[0] && pend[1]) ? 1 - last_srv : (pend[0] ? 0 : 1);
        checks++;
        if ((req0_ready_o && req1_ready_o) || k != exp_k) begin
          errors++; $display("FAIL contention_order%0d: got %b%b want %0d",
                             n, req1_ready_o, req0_ready_o, exp_k);
        end
        checks++;
        if (m_addr_o !== a[k]) begin
          errors++; $display("FAIL contention_addr: got %h want %h",
                             m_addr_o, a[k]);
        end
        last_srv = k; served[k]++; n++; upd[k] = 1;
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL contention_timeout: got %0d want 4", n);
    end
    @(negedge clk_i);
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, a1, d0;
    a0 = $urandom; a1 = $urandom; d0 = $urandom;
    @(negedge clk_i);
    set_req(0, 1'b1, a0, d0, 4'hF, 8'd0);
    m_ready_i = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk_i);
      if (i == 0) set_req(1, 1'b1, a1, $urandom, 4'h3, 8'd0);
      m_ready_i = (i == 5);
      #1; checks++;
      if ({m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o, req0_ready_o,
           req1_ready_o} !== {1'b1, a0, d0, 4'hF, (i == 5), 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b %h %h %h r%b%b", i, m_valid_o,
                 m_addr_o, m_wdata_o, m_wstrb_o, req0_ready_o, req1_ready_o);
      end
    end
    @(negedge clk_i);
    set_req(0, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b1;
    #1; checks++;
    if (m_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_bubble: got %b want 0", m_valid_o);
    end
    @(negedge clk_i);
    #1; checks++;
    if ({m_valid_o, m_addr_o, req1_ready_o, req0_ready_o} !==
        {1'b1, a1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_next: got %b %h r1%b r0%b want 1 %h 1 0",
                         m_valid_o, m_addr_o, req1_ready_o, req0_ready_o, a1);
    end
    @(negedge clk_i);
    set_req(1, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b0;
  endtask

  task automatic test_boundaries();
    run_txn(0, 1'b0, 32'h300, 32'h0, 8'd0, 1, 1, 1'b0);
    run_txn(1, 1'b0, 32'h400, 32'h0, 8'd255, 0, 1, 1'b0);
    @(negedge clk_i);
    m_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_rdata_i = $urandom;
      #1; checks++;
      if ({m_valid_o, req0_rvalid_o, req1_rvalid_o, req0_rdata_o,
           req1_rdata_o} !== '0) begin
        errors++; $display("FAIL stray_rvalid: got %b%b%b want 000",
                           m_valid_o, req0_rvalid_o, req1_rvalid_o);
      end
      @(negedge clk_i);
    end
    m_rvalid_i = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom,
              $urandom, 8'($urandom_range(0, 15)), $urandom_range(0, 3),
              2, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a0, a1;
    a0 = $urandom; a1 = $urandom;
    @(negedge clk_i);
    set_req(1, 1'b1, 32'h500, 32'h0, 4'h0, 8'd7);
    m_ready_i = 1'b1;
    @(negedge clk_i);
    #1; checks++;
    if ({m_valid_o, req1_ready_o} !== 2'b11) begin
      errors++; $display("FAIL rst_req: got %b%b want 11",
                         m_valid_o, req1_ready_o);
    end
    @(negedge clk_i);
    set_req(1, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid_i = 1'b1; m_rdata_i = $urandom;
      #1; checks++;
      if (req1_rvalid_o !== 1'b1) begin
        errors++; $display("FAIL rst_beat%0d: got %b want 1", b,
                           req1_rvalid_o);
      end
      @(negedge clk_i);
    end
    m_rdata_i = $urandom;
    arst_n_i = 1'b0;
    #1; checks++;
    if ({req1_rvalid_o, req1_rlast_o, req1_rdata_o, req0_rvalid_o,
         m_valid_o} !== '0) begin
      errors++; $display("FAIL rst_mid: got v%b l%b %h want 0",
                         req1_rvalid_o, req1_rlast_o, req1_rdata_o);
    end
    @(negedge clk_i);
    arst_n_i = 1'b1;
    #1; checks++;
    if ({req0_rvalid_o, req1_rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL rst_tail: got %b%b want 00",
                         req0_rvalid_o, req1_rvalid_o);
    end
    @(negedge clk_i);
    m_rvalid_i = 1'b0;
    set_req(0, 1'b1, a0, $urandom, 4'hF, 8'd0);
    set_req(1, 1'b1, a1, $urandom, 4'hF, 8'd0);
    m_ready_i = 1'b1;
    @(negedge clk_i);
    #1; checks++;
    if ({req0_ready_o, req1_ready_o, m_addr_o} !== {2'b10, a0}) begin
      errors++; $display("FAIL rst_first: got %b%b %h want 10 %h",
                         req0_ready_o, req1_ready_o, m_addr_o, a0);
    end
    @(negedge clk_i);
    set_req(0, 1'b0, '0, '0, '0, '0);
    @(negedge clk_i);
    #1; checks++;
    if ({req0_ready_o, req1_ready_o, m_addr_o} !== {2'b01, a1}) begin
      errors++; $display("FAIL rst_second: got %b%b %h want 01 %h",
                         req0_ready_o, req1_ready_o, m_addr_o, a1);
    end
    @(negedge clk_i);
    set_req(1, 1'b0, '0, '0, '0, '0);
    m_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_contention();
    test_backpressure();
    test_boundaries();
    test_random();
    test_reset_mid_burst();
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
